lfsr_random: RTL

LFSR_RANDOM -- requirements
Module: lfsr_random

---
 rtl/lfsr_random.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_random.sv
// ---------------------------------------------------------------------------
// lfsr_random
//
// Galois LFSR random source with a bounded-range drawing engine. While idle
// the LFSR can free-run every cycle. A draw request latches an exclusive
// upper bound and then uses rejection sampling: each cycle the LFSR steps
// and its low bits, masked to the smallest all-ones value covering the
// bound, form a candidate. Candidates below the bound are accepted. If
// MAX_TRIES candidates in a row are rejected, the draw ends with data 0
// and a miss flag so the caller never waits forever.
//
// Ports
//   clk        rising-edge clock
//   RESET_N    asynchronous active-low reset
//   seed_load  load 'seed' into the LFSR (SEED if 'seed' is zero), abort draw
//   seed       seed value, WIDTH bits
//   free_run   step the LFSR every cycle while idle
//   req        draw request, only looked at while idle
//   range      exclusive upper bound of the draw; 0 means 2^OUT_W
//   busy       high while a draw is in progress
//   valid      one-cycle pulse when 'data' holds a new draw
//   data       drawn value, held until the next draw completes
//   miss       pulses with 'valid' when every attempt was rejected
//   state_o    current LFSR state
// ---------------------------------------------------------------------------
module lfsr_random #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned      OUT_W     = 5,
    parameter int unsigned      MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             free_run,
    input  logic             req,
    input  logic [OUT_W-1:0] range,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] data,
    output logic             miss,
    output logic [WIDTH-1:0] state_o
);

    // The try counter only has to reach MAX_TRIES-1; the final reject is
    // detected by comparison rather than by counting past it.
    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } fsm_e;

    fsm_e             fsm_q,        fsm_d;
    logic [WIDTH-1:0] lfsr_q,       lfsr_d;
    logic [TRY_W-1:0] tries_q,      tries_d;
    logic [OUT_W-1:0] rangeLatch_q, rangeLatch_d;
    logic [OUT_W-1:0] data_q,       data_d;
    logic             valid_q,      valid_d;
    logic             miss_q,       miss_d;

    logic [WIDTH-1:0] stepped;
    logic [OUT_W-1:0] rangeMinus1;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] candidate;
    logic             accept;

    // One Galois shift: shift right and fold the taps back in when a one
    // falls out of the bottom.
    function automatic logic [WIDTH-1:0] lfsrStep(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // The mask is the smallest 2^k-1 that still covers range-1, so each
    // candidate is accepted with probability above one half. A range of 0
    // wraps range-1 to all ones, which gives the full-width mask and makes
    // every candidate acceptable.
    always_comb begin
        stepped     = lfsrStep(lfsr_q);
        rangeMinus1 = rangeLatch_q - OUT_W'(1);
        mask        = '0;
        for (int i = 0; i < OUT_W; i++) begin
            mask[i] = |(rangeMinus1 >> i);
        end
        candidate   = stepped[OUT_W-1:0] & mask;
        accept      = (rangeLatch_q == '0) || (candidate < rangeLatch_q);
    end

    // Next-state logic. seed_load overrides both states and silently drops
    // any draw in progress. Any path that would leave the LFSR at zero is
    // redirected to SEED, since an all-zero Galois LFSR never leaves zero.
    always_comb begin
        fsm_d        = fsm_q;
        lfsr_d       = lfsr_q;
        tries_d      = tries_q;
        rangeLatch_d = rangeLatch_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        miss_d       = 1'b0;

        if (seed_load) begin
            lfsr_d  = (seed == '0) ? SEED : seed;
            fsm_d   = IDLE;
            tries_d = '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (free_run) begin
                        lfsr_d = stepped;
                    end
                    if (req) begin
                        rangeLatch_d = range;
                        tries_d      = '0;
                        fsm_d        = DRAW;
                    end
                end
                DRAW: begin
                    lfsr_d = stepped;
                    if (accept) begin
                        data_d  = candidate;
                        valid_d = 1'b1;
                        fsm_d   = IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        data_d  = '0;
                        valid_d = 1'b1;
                        miss_d  = 1'b1;
                        tries_d = '0;
                        fsm_d   = IDLE;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end

        if (lfsr_d == '0) begin
            lfsr_d = SEED;
        end
    end

    // State registers; reset returns everything to the idle, seeded state
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm_q        <= IDLE;
            lfsr_q       <= SEED;
            tries_q      <= '0;
            rangeLatch_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            lfsr_q       <= lfsr_d;
            tries_q      <= tries_d;
            rangeLatch_q <= rangeLatch_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            miss_q       <= miss_d;
        end
    end

    assign busy    = (fsm_q == DRAW);
    assign valid   = valid_q;
    assign data    = data_q;
    assign miss    = miss_q;
    assign state_o = lfsr_q;

endmodule
